// File: rtl/baccarat_fsm_if.sv
// Card-table signal bundle between the baccarat deal controller and its
// card/score datapath. The controller issues load strobes and drives the
// result lamps; the datapath returns the third player card and both scores.
interface baccarat_fsm_if;
   logic [3:0] pcard3_out;
   logic [3:0] pscore_out;
   logic [3:0] dscore_out;
   logic       load_pcard1;
   logic       load_pcard2;
   logic       load_pcard3;
   logic       load_dcard1;
   logic       load_dcard2;
   logic       load_dcard3;
   logic       player_win_light;
   logic       dealer_win_light;

   // Controller side: consumes card/score values, issues strobes and lamps
   modport master (
      input  pcard3_out, pscore_out, dscore_out,
      output load_pcard1, load_pcard2, load_pcard3,
      output load_dcard1, load_dcard2, load_dcard3,
      output player_win_light, dealer_win_light
   );

   // Datapath side: provides card/score values, obeys strobes
   modport slave (
      output pcard3_out, pscore_out, dscore_out,
      input  load_pcard1, load_pcard2, load_pcard3,
      input  load_dcard1, load_dcard2, load_dcard3,
      input  player_win_light, dealer_win_light
   );
endinterface

// File: rtl/baccarat_fsm.sv
// Baccarat deal controller. Deals two cards each to player and dealer,
// applies the natural / player-third-card / banker-third-card rules, then
// sits in DONE showing the result lamps until reset.
module baccarat_fsm (
   input  logic           slow_clock,
   input  logic           resetb,
   baccarat_fsm_if.master bus
);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      P1    = 4'd1,
      D1    = 4'd2,
      P2    = 4'd3,
      D2    = 4'd4,
      EVAL1 = 4'd5,
      P3    = 4'd6,
      EVAL2 = 4'd7,
      D3    = 4'd8,
      DONE  = 4'd9
   } state_t;

   state_t state_reg;
   state_t state_next;

   // Point value of a card rank: ace..nine count face value, ten and court cards count zero
   function automatic logic [3:0] point_value(input logic [3:0] rank);
      return (rank >= 4'd10) ? 4'd0 : rank;
   endfunction

   // A two-card total of 8 or 9 ends the hand immediately
   function automatic logic is_natural(input logic [3:0] score);
      return (score == 4'd8) || (score == 4'd9);
   endfunction

   // Banker third-card rule given banker score and the player's third-card value
   function automatic logic banker_draws(input logic [3:0] dscore, input logic [3:0] v);
      logic draw;
      case (dscore)
         4'd0, 4'd1, 4'd2: draw = 1'b1;
         4'd3:             draw = (v != 4'd8);
         4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
         4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
         4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
         default:          draw = 1'b0;
      endcase
      return draw;
   endfunction

   // State register; reset aborts any hand immediately
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   // Next-state logic: fixed deal order, then the two decision points
   always_comb begin
      state_next = IDLE;
      case (state_reg)
         IDLE:  state_next = P1;
         P1:    state_next = D1;
         D1:    state_next = P2;
         P2:    state_next = D2;
         D2:    state_next = EVAL1;
         EVAL1: begin
            if (is_natural(bus.pscore_out) || is_natural(bus.dscore_out))
               state_next = DONE;
            else if (bus.pscore_out <= 4'd5)
               state_next = P3;
            else if ((bus.pscore_out <= 4'd7) && (bus.dscore_out <= 4'd5))
               state_next = D3;
            else
               state_next = DONE;  // player stands and banker stands, or out-of-range score
         end
         P3:    state_next = EVAL2;
         EVAL2: begin
            if (banker_draws(bus.dscore_out, point_value(bus.pcard3_out)))
               state_next = D3;
            else
               state_next = DONE;
         end
         D3:    state_next = DONE;
         DONE:  state_next = DONE;
         default: state_next = IDLE;  // unused encodings recover to IDLE
      endcase
   end

   // Output decode: one load strobe per dealing state, lamps only in DONE
   always_comb begin
      bus.load_pcard1      = 1'b0;
      bus.load_pcard2      = 1'b0;
      bus.load_pcard3      = 1'b0;
      bus.load_dcard1      = 1'b0;
      bus.load_dcard2      = 1'b0;
      bus.load_dcard3      = 1'b0;
      bus.player_win_light = 1'b0;
      bus.dealer_win_light = 1'b0;
      case (state_reg)
         P1: bus.load_pcard1 = 1'b1;
         D1: bus.load_dcard1 = 1'b1;
         P2: bus.load_pcard2 = 1'b1;
         D2: bus.load_dcard2 = 1'b1;
         P3: bus.load_pcard3 = 1'b1;
         D3: bus.load_dcard3 = 1'b1;
         DONE: begin
            if (bus.pscore_out > bus.dscore_out) begin
               bus.player_win_light = 1'b1;
            end else if (bus.pscore_out < bus.dscore_out) begin
               bus.dealer_win_light = 1'b1;
            end else begin
               bus.player_win_light = 1'b1;
               bus.dealer_win_light = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench for the baccarat deal controller: reset behaviour, the
// described hands, and a sweep of the banker third-card table.
module tb_baccarat_fsm;

   logic slow_clock;
   logic resetb;
   int   n_tests = 0;
   int   n_fail  = 0;

   baccarat_fsm_if bus ();

   baccarat_fsm dut (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .bus        (bus)
   );

   // Output vector layout: {pc1, pc2, pc3, dc1, dc2, dc3, player_lamp, dealer_lamp}
   localparam logic [7:0] O_NONE = 8'b000000_00;
   localparam logic [7:0] O_P1   = 8'b100000_00;
   localparam logic [7:0] O_P2   = 8'b010000_00;
   localparam logic [7:0] O_P3   = 8'b001000_00;
   localparam logic [7:0] O_D1   = 8'b000100_00;
   localparam logic [7:0] O_D2   = 8'b000010_00;
   localparam logic [7:0] O_D3   = 8'b000001_00;
   localparam logic [7:0] O_PWIN = 8'b000000_10;
   localparam logic [7:0] O_DWIN = 8'b000000_01;
   localparam logic [7:0] O_TIE  = 8'b000000_11;

   // Banker draw masks, bit (card-1) set when the banker draws, indexed by banker score
   logic [12:0] draw_mask [0:7];
   logic [7:0]  mon_o;

   initial begin
      slow_clock = 1'b0;
      forever #5 slow_clock = ~slow_clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1);
   end

   function automatic logic [7:0] outs();
      return {bus.load_pcard1, bus.load_pcard2, bus.load_pcard3,
              bus.load_dcard1, bus.load_dcard2, bus.load_dcard3,
              bus.player_win_light, bus.dealer_win_light};
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic [7:0] exp);
      @(posedge slow_clock);
      #1;
      check(tag, outs(), exp);
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      #2;
      check("rst_async", outs(), O_NONE);
      @(posedge slow_clock);
      #1;
      check("rst_hold", outs(), O_NONE);
      resetb = 1'b1;
   endtask

   task automatic new_hand();
      do_reset();
      step("deal_p1", O_P1);
      step("deal_d1", O_D1);
      step("deal_p2", O_P2);
      step("deal_d2", O_D2);
   endtask

   // Per-cycle invariants: at most one strobe, and never a lamp alongside a strobe
   always @(negedge slow_clock) begin
      if (resetb) begin
         mon_o = outs();
         check("one_load", {7'd0, $onehot0(mon_o[7:2])}, 8'd1);
         check("lamp_with_load", {6'd0, (|mon_o[7:2]) ? mon_o[1:0] : 2'b00}, 8'd0);
      end
   end

   initial begin
      draw_mask[0] = 13'h1FFF;
      draw_mask[1] = 13'h1FFF;
      draw_mask[2] = 13'h1FFF;
      draw_mask[3] = 13'h1F7F;  // all but the eight
      draw_mask[4] = 13'h007E;  // cards 2..7
      draw_mask[5] = 13'h0078;  // cards 4..7
      draw_mask[6] = 13'h0060;  // cards 6..7
      draw_mask[7] = 13'h0000;

      resetb         = 1'b1;
      bus.pcard3_out = 4'd0;
      bus.pscore_out = 4'd0;
      bus.dscore_out = 4'd0;
      #1;

      // Reset mid-hand during P2
      do_reset();
      step("rm_p1", O_P1);
      step("rm_d1", O_D1);
      step("rm_p2", O_P2);
      #3;
      resetb = 1'b0;
      #1;
      check("rm_drop_p2", outs(), O_NONE);
      @(posedge slow_clock);
      #1;
      check("rm_idle", outs(), O_NONE);
      resetb = 1'b1;
      step("rm_rel_p1", O_P1);
      $display("[TB] hand reset_mid_p2 checked");

      // Natural: player 8 vs banker 3
      new_hand();
      bus.pscore_out = 4'd8;
      bus.dscore_out = 4'd3;
      step("nat_eval1", O_NONE);
      step("nat_done", O_PWIN);
      step("nat_absorb", O_PWIN);
      $display("[TB] hand natural checked");

      // Player draws, banker draws, then dealer wins
      new_hand();
      bus.pscore_out = 4'd4;
      bus.dscore_out = 4'd5;
      step("pb_eval1", O_NONE);
      step("pb_p3", O_P3);
      bus.pcard3_out = 4'd6;
      step("pb_eval2", O_NONE);
      step("pb_d3", O_D3);
      bus.pscore_out = 4'd2;
      bus.dscore_out = 4'd7;
      step("pb_done", O_DWIN);
      $display("[TB] hand player_draw_banker_draw checked");

      // Player stands, banker draws, tie
      new_hand();
      bus.pscore_out = 4'd7;
      bus.dscore_out = 4'd5;
      step("ps_eval1", O_NONE);
      step("ps_d3", O_D3);
      bus.dscore_out = 4'd7;
      step("ps_done", O_TIE);
      $display("[TB] hand player_stand_banker_draw checked");

      // Face card third card: banker 4 stands on v=0
      new_hand();
      bus.pscore_out = 4'd3;
      bus.dscore_out = 4'd4;
      step("fc_eval1", O_NONE);
      step("fc_p3", O_P3);
      bus.pcard3_out = 4'd12;
      step("fc_eval2", O_NONE);
      step("fc_done", O_DWIN);
      $display("[TB] hand face_card checked");

      // Banker 3 stands on an eight
      new_hand();
      bus.pscore_out = 4'd3;
      bus.dscore_out = 4'd3;
      step("b3e_eval1", O_NONE);
      step("b3e_p3", O_P3);
      bus.pcard3_out = 4'd8;
      step("b3e_eval2", O_NONE);
      step("b3e_done", O_TIE);
      $display("[TB] hand banker3_eight checked");

      // Banker 3 draws on a nine
      new_hand();
      bus.pscore_out = 4'd3;
      bus.dscore_out = 4'd3;
      step("b3n_eval1", O_NONE);
      step("b3n_p3", O_P3);
      bus.pcard3_out = 4'd9;
      step("b3n_eval2", O_NONE);
      step("b3n_d3", O_D3);
      step("b3n_done", O_TIE);
      $display("[TB] hand banker3_nine checked");

      // Banker table sweep with player score 0 so the player always draws
      for (int d = 0; d < 8; d++) begin
         for (int c = 1; c < 14; c++) begin
            logic [12:0] mask;
            logic        draw;
            mask = draw_mask[d];
            draw = mask[c-1];
            new_hand();
            bus.pscore_out = 4'd0;
            bus.dscore_out = d[3:0];
            bus.pcard3_out = 4'd0;
            step($sformatf("bt_eval1_d%0d_c%0d", d, c), O_NONE);
            step($sformatf("bt_p3_d%0d_c%0d", d, c), O_P3);
            bus.pcard3_out = c[3:0];
            step($sformatf("bt_eval2_d%0d_c%0d", d, c), O_NONE);
            step($sformatf("bt_next_d%0d_c%0d", d, c),
                 draw ? O_D3 : ((d == 0) ? O_TIE : O_DWIN));
            $display("[TB] banker dscore=%0d pcard3=%0d expect %s", d, c, draw ? "draw" : "stand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/baccarat_fsm.md
BACCARAT_FSM -- requirements
Module: baccarat_fsm

Interface
REQ-001 Ports SHALL be exactly the following, all 1-bit unless stated:
- slow_clock  in  1  sole clock; all state changes on rising edge
- resetb  in  1  reset, asynchronous, active-low
- pcard3_out  in  4  player third card, rank 1..13 (0 = empty)
- pscore_out  in  4  player hand score 0..9
- dscore_out  in  4  dealer hand score 0..9
- load_pcard1, load_pcard2, load_pcard3  out  player card-register load strobes
- load_dcard1, load_dcard2, load_dcard3  out  dealer card-register load strobes
- player_win_light, dealer_win_light  out  result lamps
REQ-002 One clock (slow_clock); resetb is asynchronous and active-low.
REQ-003 All outputs SHALL be Moore outputs, decoded from the state register only, except the win lights, which are decoded from the state plus pscore_out/dscore_out.

Function
REQ-004 States SHALL be: IDLE, P1, D1, P2, D2, EVAL1, P3, EVAL2, D3, DONE.
REQ-005 Each load output SHALL be 1 in exactly one state: P1->load_pcard1, D1->load_dcard1, P2->load_pcard2, D2->load_dcard2, P3->load_pcard3, D3->load_dcard3. It SHALL be 0 in all other states.
REQ-006 The deal sequence SHALL be unconditional: IDLE->P1->D1->P2->D2->EVAL1, one state per clock.
REQ-007 In EVAL1, a natural (pscore_out or dscore_out in 8..9) SHALL go to DONE.
REQ-008 In EVAL1 with no natural, pscore_out 0..5 SHALL go to P3.
REQ-009 In EVAL1 with no natural and pscore_out 6..7:
- dscore_out 0..5 -> D3
- dscore_out 6..7 -> DONE
REQ-010 P3 SHALL go to EVAL2. EVAL2 SHALL evaluate the banker rule using v = point value of pcard3_out (1..9 -> same value; 10..13 -> 0). The banker draws (-> D3), otherwise -> DONE, per:
- dscore 0..2: always draw
- dscore 3: draw if v != 8
- dscore 4: draw if v in 2..7
- dscore 5: draw if v in 4..7
- dscore 6: draw if v in 6..7
- dscore 7: never draw
REQ-011 D3 SHALL go to DONE.
REQ-012 DONE SHALL be absorbing; only resetb exits it.
REQ-013 Win lights SHALL be 0 in every state except DONE. In DONE:
- pscore_out > dscore_out -> player_win_light=1
- pscore_out < dscore_out -> dealer_win_light=1
- equal -> both lights 1
REQ-014 All score comparisons SHALL be unsigned 4-bit. Score inputs above 9 SHALL be treated as non-natural; such values are not checked for outcome.
REQ-015 Decisions SHALL use the inputs sampled on the edge leaving EVAL1/EVAL2. This is one cycle after the corresponding load, so datapath registers are already valid.
REQ-016 Hand lengths SHALL be:
- minimum (natural): 6 edges from IDLE to DONE
- maximum: 9 edges (IDLE..D3)

Reset
REQ-017 resetb=0 SHALL force IDLE immediately, without waiting for a clock edge. All six load outputs and both lights SHALL go to 0 asynchronously.
REQ-018 While resetb=0 the state SHALL hold IDLE. The first rising edge with resetb=1 SHALL enter P1.
REQ-019 Reset asserted in any state, including mid-deal (e.g. P2 or P3), SHALL abort the hand. No load strobe may remain high after resetb falls.
REQ-020 Encoding SHALL have no unreachable lock-up: any illegal state value SHALL transition to IDLE on the next edge.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Reset mid-hand: assert resetb=0 during P2 -> load_pcard2 drops to 0 before the next edge; state IDLE; after release, load_pcard1=1 one edge later.
- Natural: after D2 drive pscore=8, dscore=3 -> EVAL1 then DONE; load_pcard3 and load_dcard3 never asserted; player_win_light=1, dealer_win_light=0.
- Player draws, banker draws: pscore=4, dscore=5, pcard3=6 -> P3, EVAL2, D3, DONE. Then with dscore=7, pscore=2 -> dealer_win_light=1 only.
- Player stands, banker draws: pscore=7, dscore=5 -> EVAL1 goes to D3 with no P3. Then with dscore=7 -> both lights 1.
- Face-card third card: pscore=3, dscore=4, pcard3=12 (v=0) -> EVAL2 goes to DONE, no load_dcard3. Repeat with dscore=3, pcard3=8 -> DONE; dscore=3, pcard3=9 -> D3.
- Exhaustive banker table: for all dscore 0..7 and pcard3 1..13, the EVAL2 next state SHALL match REQ-010. Assertions: at most one load output high per cycle; lights 0 outside DONE.
